base_2_normalize_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational zero-exponent blocks.
- Splits an IEEE-754 value into:
  - `c`: the same sign and mantissa with the exponent field forced to the bias, so |c| is in [1,2).
  - `e`: the signed unbiased base-2 exponent.
- Supports HALF, SINGLE and DOUBLE from one RTL body.
- Adds iterative subnormal normalisation (one shift per cycle), which the earlier blocks lacked.
- Sits in front of log2/divide/sqrt datapaths that need a normalised mantissa plus exponent.

---
 rtl/float_fmt_pkg.sv | 27 ++
 rtl/base_2_normalize_seq_if.sv | 29 ++
 rtl/fp_field_decode.sv | 31 +++
 rtl/base_2_normalize_seq.sv | 157 +++++++++++++++
 tb/tb_base_2_normalize_seq.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/float_fmt_pkg.sv
// IEEE-754 format constants and FSM state type
// shared by the base-2 normalize block.
package float_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } norm_state_t;

  function automatic int exp_bits(string p);
    if (p == "DOUBLE") return 11;
    if (p == "SINGLE") return 8;
    return 5;
  endfunction

  function automatic int mant_bits(string p);
    if (p == "DOUBLE") return 52;
    if (p == "SINGLE") return 23;
    return 10;
  endfunction

  function automatic int bias(string p);
    return (1 << (exp_bits(p) - 1)) - 1;
  endfunction

endpackage

// File: rtl/base_2_normalize_seq_if.sv
// Operand/result handshake bundle for base_2_normalize_seq.
// in_valid/in_ready/a in, out_valid/out_ready/c/e/flags out.
interface base_2_normalize_seq_if #(
  parameter int BITS   = 16,
  parameter int E_BITS = 6
);
  logic                     in_valid;
  logic                     in_ready;
  logic [BITS-1:0]          a;
  logic                     out_valid;
  logic                     out_ready;
  logic [BITS-1:0]          c;
  logic signed [E_BITS-1:0] e;
  logic                     is_zero;
  logic                     is_special;
  logic                     was_subnormal;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, c, e,
    input  is_zero, is_special, was_subnormal
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, c, e,
    output is_zero, is_special, was_subnormal
  );
endinterface

// File: rtl/fp_field_decode.sv
// Splits an IEEE-754 word into sign/exp/frac and classifies it.
// Ports: a in; sign, exp, frac, is_zero, is_sub, is_special out.
module fp_field_decode
  import float_fmt_pkg::*;
#(
  parameter string PRECISION = "HALF"
) (
  input  logic [exp_bits(PRECISION)+mant_bits(PRECISION):0] a,
  output logic                                 sign,
  output logic [exp_bits(PRECISION)-1:0]       exp,
  output logic [mant_bits(PRECISION)-1:0]      frac,
  output logic                                 is_zero,
  output logic                                 is_sub,
  output logic                                 is_special
);
  localparam int EB = exp_bits(PRECISION);
  localparam int MB = mant_bits(PRECISION);

  assign sign = a[EB+MB];
  assign exp  = a[EB+MB-1:MB];
  assign frac = a[MB-1:0];

  logic exp_zero;
  logic frac_zero;

  assign exp_zero   = (exp == '0);
  assign frac_zero  = (frac == '0);
  assign is_zero    = exp_zero && frac_zero;
  assign is_sub     = exp_zero && !frac_zero;
  assign is_special = &exp;
endmodule

// File: rtl/base_2_normalize_seq.sv
// Handshaked split of an IEEE-754 value into c (|c| in [1,2)) and e.
// Ports: clk, rst_n, io (slave: a in, c/e/flags out, valid/ready).
module base_2_normalize_seq
  import float_fmt_pkg::*;
#(
  parameter string PRECISION = "HALF",
  parameter int    BITS      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  base_2_normalize_seq_if.slave  io
);
  localparam int EB     = exp_bits(PRECISION);
  localparam int MB     = mant_bits(PRECISION);
  localparam int BIAS   = bias(PRECISION);
  localparam int W      = 1 + EB + MB;
  localparam int E_BITS = EB + 1;

  localparam logic [EB-1:0] BIAS_F = EB'(BIAS);

  if (PRECISION != "HALF" && PRECISION != "SINGLE" &&
      PRECISION != "DOUBLE") begin : g_bad_prec
    $error("base_2_normalize_seq: bad PRECISION");
  end

  if (BITS != W) begin : g_bad_bits
    $error("base_2_normalize_seq: BITS mismatch");
  end

  logic          d_sign;
  logic [EB-1:0] d_exp;
  logic [MB-1:0] d_frac;
  logic          d_zero;
  logic          d_sub;
  logic          d_special;

  fp_field_decode #(
    .PRECISION (PRECISION)
  ) u_dec (
    .a          (io.a),
    .sign       (d_sign),
    .exp        (d_exp),
    .frac       (d_frac),
    .is_zero    (d_zero),
    .is_sub     (d_sub),
    .is_special (d_special)
  );

  norm_state_t              state;
  norm_state_t              state_n;
  logic                     rdy_q;
  logic [MB:0]              m_q;
  logic [MB:0]              m_n;
  logic [MB:0]              m_sh;
  logic signed [E_BITS-1:0] e_q;
  logic signed [E_BITS-1:0] e_n;
  logic [W-1:0]             c_q;
  logic [W-1:0]             c_n;
  logic                     sign_q;
  logic                     sign_n;
  logic                     z_q, z_n;
  logic                     s_q, s_n;
  logic                     sub_q, sub_n;

  assign m_sh = m_q << 1;

  always_comb begin
    state_n = state;
    m_n     = m_q;
    e_n     = e_q;
    c_n     = c_q;
    sign_n  = sign_q;
    z_n     = z_q;
    s_n     = s_q;
    sub_n   = sub_q;
    unique case (state)
      IDLE: begin
        if (io.in_valid && rdy_q) begin
          sign_n = d_sign;
          z_n    = 1'b0;
          s_n    = 1'b0;
          sub_n  = 1'b0;
          unique case (1'b1)
            d_zero: begin
              c_n     = io.a;
              e_n     = '0;
              z_n     = 1'b1;
              state_n = DONE;
            end
            d_special: begin
              c_n     = io.a;
              e_n     = '0;
              s_n     = 1'b1;
              state_n = DONE;
            end
            d_sub: begin
              m_n     = {1'b0, d_frac};
              e_n     = E_BITS'(1 - BIAS);
              sub_n   = 1'b1;
              state_n = NORM;
            end
            default: begin
              c_n     = {d_sign, BIAS_F, d_frac};
              e_n     = {1'b0, d_exp} - E_BITS'(BIAS);
              state_n = DONE;
            end
          endcase
        end
      end
      NORM: begin
        m_n = m_sh;
        e_n = e_q - E_BITS'(1);
        // Hidden-bit position reached: mantissa is normalised.
        if (m_sh[MB]) begin
          c_n     = {sign_q, BIAS_F, m_sh[MB-1:0]};
          state_n = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rdy_q  <= 1'b0;
      m_q    <= '0;
      e_q    <= '0;
      c_q    <= '0;
      sign_q <= 1'b0;
      z_q    <= 1'b0;
      s_q    <= 1'b0;
      sub_q  <= 1'b0;
    end else begin
      state  <= state_n;
      rdy_q  <= (state_n == IDLE);
      m_q    <= m_n;
      e_q    <= e_n;
      c_q    <= c_n;
      sign_q <= sign_n;
      z_q    <= z_n;
      s_q    <= s_n;
      sub_q  <= sub_n;
    end
  end

  assign io.in_ready      = rdy_q;
  assign io.out_valid     = (state == DONE);
  assign io.c             = c_q;
  assign io.e             = e_q;
  assign io.is_zero       = z_q;
  assign io.is_special    = s_q;
  assign io.was_subnormal = sub_q;
endmodule

// File: tb/tb_base_2_normalize_seq.sv
// Random + directed bench for base_2_normalize_seq in HALF,
// SINGLE and DOUBLE against an arithmetic reference model.
module tb_base_2_normalize_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [2:0]  iv = '0;
  logic [2:0]  orr = '0;
  logic [63:0] av [3];
  logic [2:0]  ovl, irdy, fz, fs, fsub;
  logic [63:0] cc [3];
  int          ee [3];

  base_2_normalize_seq_if #(.BITS(16), .E_BITS(6))  ih ();
  base_2_normalize_seq_if #(.BITS(32), .E_BITS(9))  is ();
  base_2_normalize_seq_if #(.BITS(64), .E_BITS(12)) id ();

  base_2_normalize_seq #(.PRECISION("HALF"), .BITS(16)) u_h (
    .clk(clk), .rst_n(rst_n), .io(ih));
  base_2_normalize_seq #(.PRECISION("SINGLE"), .BITS(32)) u_s (
    .clk(clk), .rst_n(rst_n), .io(is));
  base_2_normalize_seq #(.PRECISION("DOUBLE"), .BITS(64)) u_d (
    .clk(clk), .rst_n(rst_n), .io(id));

  assign ih.in_valid = iv[0];
  assign is.in_valid = iv[1];
  assign id.in_valid = iv[2];
  assign ih.out_ready = orr[0];
  assign is.out_ready = orr[1];
  assign id.out_ready = orr[2];
  assign ih.a = av[0][15:0];
  assign is.a = av[1][31:0];
  assign id.a = av[2];

  assign ovl  = {id.out_valid, is.out_valid, ih.out_valid};
  assign irdy = {id.in_ready, is.in_ready, ih.in_ready};
  assign fz   = {id.is_zero, is.is_zero, ih.is_zero};
  assign fs   = {id.is_special, is.is_special, ih.is_special};
  assign fsub = {id.was_subnormal, is.was_subnormal,
                 ih.was_subnormal};
  assign cc[0] = 64'(ih.c);
  assign cc[1] = 64'(is.c);
  assign cc[2] = id.c;
  assign ee[0] = int'($signed(ih.e));
  assign ee[1] = int'($signed(is.e));
  assign ee[2] = int'($signed(id.e));

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int ebits(int f);
    return (f == 0) ? 5 : (f == 1) ? 8 : 11;
  endfunction

  function automatic int mbits(int f);
    return (f == 0) ? 10 : (f == 1) ? 23 : 52;
  endfunction

  // Reference: value = (-1)^s * 1.f * 2^e, found by locating the
  // top set bit of a subnormal fraction directly.
  function automatic void model(
    input int f, input logic [63:0] a,
    output logic [63:0] c, output int e,
    output logic z, output logic s, output logic sub,
    output int lat);
    int eb, mb, bs, p, k;
    logic [63:0] ex, fr, sg, emax, fmask;
    eb = ebits(f);
    mb = mbits(f);
    bs = (1 << (eb - 1)) - 1;
    emax = (64'd1 << eb) - 1;
    fmask = (64'd1 << mb) - 1;
    ex = (a >> mb) & emax;
    fr = a & fmask;
    sg = (a >> (mb + eb)) & 64'd1;
    z = 0; s = 0; sub = 0; lat = 1; e = 0; c = a;
    if (ex == 0 && fr == 0) z = 1;
    else if (ex == emax) s = 1;
    else if (ex == 0) begin
      p = 0;
      for (int i = 0; i < mb; i++) if (fr[i]) p = i;
      k = mb - p;
      sub = 1;
      e = 1 - bs - k;
      lat = 1 + k;
      c = (sg << (mb + eb)) | (64'(bs) << mb) |
          ((fr << k) & fmask);
    end else begin
      e = int'(ex) - bs;
      c = (sg << (mb + eb)) | (64'(bs) << mb) | fr;
    end
  endfunction

  task automatic pin(int f, logic [63:0] a, logic [63:0] xc,
                     int xe, int xlat, logic [2:0] xfl);
    logic [63:0] c; int e, lat; logic z, s, sub;
    model(f, a, c, e, z, s, sub, lat);
    chk("pin_c", c, xc);
    chk("pin_e", 64'(e), 64'(xe));
    chk("pin_lat", 64'(lat), 64'(xlat));
    chk("pin_flags", 64'({z, s, sub}), 64'(xfl));
  endtask

  task automatic wait_ready(int f);
    int n = 0;
    while (!irdy[f] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", 64'(irdy[f]), 64'd1);
  endtask

  task automatic txn(int f, logic [63:0] a, int stall);
    logic [63:0] xc; int xe, xlat, lat;
    logic xz, xs, xsub;
    model(f, a, xc, xe, xz, xs, xsub, xlat);
    @(negedge clk);
    iv[f] = 1'b1;
    av[f] = a;
    orr[f] = (stall == 0);
    wait_ready(f);
    @(negedge clk);
    iv[f] = 1'b0;
    av[f] = {$urandom, $urandom};
    lat = 1;
    while (!ovl[f] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(xlat));
    chk("c", cc[f], xc);
    chk("e", 64'(ee[f]), 64'(xe));
    chk("flags", 64'({fz[f], fs[f], fsub[f]}),
        64'({xz, xs, xsub}));
    if (stall > 0) begin
      // A held in_valid while busy must not be captured.
      iv[f] = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_valid", 64'(ovl[f]), 64'd1);
        chk("stall_c", cc[f], xc);
        chk("stall_e", 64'(ee[f]), 64'(xe));
        chk("stall_in_ready", 64'(irdy[f]), 64'd0);
      end
      iv[f] = 1'b0;
      orr[f] = 1'b1;
    end
    @(negedge clk);
    chk("post_valid", 64'(ovl[f]), 64'd0);
    chk("post_in_ready", 64'(irdy[f]), 64'd1);
    orr[f] = 1'b0;
  endtask

  function automatic logic [63:0] rnd_op(int f);
    logic [63:0] a, emax;
    int eb, mb, w;
    eb = ebits(f);
    mb = mbits(f);
    w = 1 + eb + mb;
    emax = (64'd1 << eb) - 1;
    a = {$urandom, $urandom};
    if (w < 64) a = a & ((64'd1 << w) - 1);
    case ($urandom_range(0, 5))
      0: a = a & ~(emax << mb);
      1: a = a | (emax << mb);
      2: a = a & (64'd1 << (w - 1));
      default: ;
    endcase
    return a;
  endfunction

  initial begin
    for (int f = 0; f < 3; f++) av[f] = '0;

    pin(0, 64'h4500, 64'h3D00, 2, 1, 3'b000);
    pin(0, 64'h0001, 64'h3C00, -24, 11, 3'b001);
    pin(1, 64'h80000000, 64'h80000000, 0, 1, 3'b100);
    pin(1, 64'h7FC00001, 64'h7FC00001, 0, 1, 3'b010);
    pin(2, 64'h000FFFFFFFFFFFFF, 64'h3FFFFFFFFFFFFFFE,
        -1023, 2, 3'b001);

    repeat (3) @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      chk("rst_in_ready", 64'(irdy[f]), 64'd0);
      chk("rst_out_valid", 64'(ovl[f]), 64'd0);
      chk("rst_c", cc[f], 64'd0);
      chk("rst_e", 64'(ee[f]), 64'd0);
      chk("rst_flags", 64'({fz[f], fs[f], fsub[f]}), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(irdy), 64'b111);

    txn(0, 64'h4500, 0);
    txn(0, 64'h0001, 0);
    txn(1, 64'h80000000, 1);
    txn(1, 64'h7FC00001, 0);
    txn(2, 64'h000FFFFFFFFFFFFF, 5);

    // Reset during NORM after four shifts.
    @(negedge clk);
    iv[0] = 1'b1;
    av[0] = 64'h0001;
    wait_ready(0);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ovl[0]), 64'd0);
    chk("midrst_c", cc[0], 64'd0);
    chk("midrst_e", 64'(ee[0]), 64'd0);
    chk("midrst_in_ready", 64'(irdy[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rel_ready", 64'(irdy[0]), 64'd1);
    txn(0, 64'h3C00, 0);

    for (int n = 0; n < 40; n++)
      for (int f = 0; f < 3; f++)
        txn(f, rnd_op(f), $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
